// File: rtl/imem_pkg.sv
// Shared definitions for the Y86-64 instruction fetch sequencer:
// instruction size, icode values, FSM state type and the icode -> length map.
package imem_pkg;

  localparam int INSTR_BYTES = 10;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Instruction length in bytes for a given icode; unknown icodes count as 1.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      IHALT, INOP, IRET:            len = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: len = 4'd2;
      IJXX, ICALL:                  len = 4'd9;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:    len = 4'd10;
      default:                      len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode -> instruction length decoder (1..10 bytes).
// Only built when IMEM_EARLY_TERM_EN is defined, since only then is it used.
`ifdef IMEM_EARLY_TERM_EN
module y86_instr_len
  import imem_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len
);

  assign len = instr_len(icode);

endmodule
`endif

// File: rtl/imem_fetch_sequencer.sv
// Sequences a single-byte-port instruction RAM for the SEQ fetch stage.
// A program loader shares the port and always wins arbitration in IDLE.
// Optional feature macro: IMEM_EARLY_TERM_EN (stop reading once the
// instruction length is known from byte0).
module imem_fetch_sequencer
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = 132,
  parameter int ADDR_W    = 8
)
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_req_valid,
  output logic                       fetch_req_ready,
  input  logic [63:0]                fetch_pc,
  output logic                       fetch_resp_valid,
  input  logic                       fetch_resp_ready,
  output logic [8*INSTR_BYTES-1:0]   fetch_bytes,
  output logic                       fetch_imem_error,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [63:0]                ld_addr,
  input  logic [7:0]                 ld_data,
  output logic                       ld_error,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [7:0]                 mem_wdata,
  input  logic [7:0]                 mem_rdata
);

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);
  localparam int          BW        = 8 * INSTR_BYTES;

  state_e            state_r, state_s;
  logic              idle_r, idle_s;
  logic [63:0]       pc_r, pc_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [3:0]        cap_idx_r;
  logic              rd_pend_r;
  logic [BW-1:0]     bytes_r, bytes_s;
  logic              err_r, err_s;
  logic              resp_valid_r, resp_valid_s;
  logic              mem_en_r, mem_en_s;
  logic              mem_we_r, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [7:0]        mem_wdata_r, mem_wdata_s;
  logic              ld_error_r, ld_error_s;
  logic [3:0]        eff_len_s;
  logic [3:0]        next_idx_s;
  logic [63:0]       next_addr_s;

  assign next_idx_s  = cnt_r + 4'd1;
  // Full 64-bit sum so an address past the end is never aliased by truncation.
  assign next_addr_s = pc_r + {60'd0, next_idx_s};

`ifdef IMEM_EARLY_TERM_EN
  logic [3:0] dec_len_s;
  logic [3:0] len_r, len_s;

  y86_instr_len u_instr_len (
    .icode (mem_rdata[7:4]),
    .len   (dec_len_s)
  );

  // Use the freshly decoded length in the cycle byte0 arrives, the stored one afterwards.
  always_comb begin
    eff_len_s = len_r;
    if (rd_pend_r && (cap_idx_r == 4'd0) && (state_r == READ)) begin
      eff_len_s = dec_len_s;
    end else begin
      eff_len_s = len_r;
    end
    if (state_r == IDLE) begin
      len_s = 4'(INSTR_BYTES);
    end else begin
      len_s = eff_len_s;
    end
  end

  // Length register; rearmed to the maximum whenever the sequencer is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_r <= 4'd0;
    end else begin
      len_r <= len_s;
    end
  end
`else
  assign eff_len_s = 4'(INSTR_BYTES);
`endif

  // Next-state, byte capture and next registered memory/handshake outputs.
  always_comb begin
    state_s      = state_r;
    idle_s       = 1'b0;
    pc_s         = pc_r;
    cnt_s        = cnt_r;
    bytes_s      = bytes_r;
    err_s        = err_r;
    resp_valid_s = resp_valid_r;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = {ADDR_W{1'b0}};
    mem_wdata_s  = 8'h00;
    ld_error_s   = 1'b0;

    // Read data from the previous cycle's access; bytes beyond the length are dropped.
    if (rd_pend_r && ((state_r == READ) || (state_r == DRAIN)) && (cap_idx_r < eff_len_s)) begin
      bytes_s[{cap_idx_r, 3'b000} +: 8] = mem_rdata;
    end else begin
      bytes_s = bytes_r;
    end

    case (state_r)
      IDLE: begin
        if (idle_r && ld_valid) begin
          if (ld_addr < MEM_LIMIT) begin
            state_s     = WRITE;
            mem_en_s    = 1'b1;
            mem_we_s    = 1'b1;
            mem_addr_s  = ld_addr[ADDR_W-1:0];
            mem_wdata_s = ld_data;
          end else begin
            ld_error_s = 1'b1;
            idle_s     = 1'b1;
          end
        end else if (idle_r && fetch_req_valid) begin
          pc_s    = fetch_pc;
          cnt_s   = 4'd0;
          bytes_s = {BW{1'b0}};
          if (fetch_pc >= MEM_LIMIT) begin
            state_s      = RESP;
            err_s        = 1'b1;
            resp_valid_s = 1'b1;
          end else begin
            state_s    = READ;
            err_s      = 1'b0;
            mem_en_s   = 1'b1;
            mem_addr_s = fetch_pc[ADDR_W-1:0];
          end
        end else begin
          idle_s = 1'b1;
        end
      end
      WRITE: begin
        state_s = IDLE;
        idle_s  = 1'b1;
      end
      READ: begin
        if (next_idx_s < eff_len_s) begin
          cnt_s = next_idx_s;
          if (next_addr_s < MEM_LIMIT) begin
            mem_en_s   = 1'b1;
            mem_addr_s = next_addr_s[ADDR_W-1:0];
          end else begin
            mem_en_s = 1'b0;
          end
        end else if (next_idx_s == eff_len_s) begin
          state_s = DRAIN;
        end else begin
          // Length-1 instruction: byte0 is captured this cycle, nothing left to drain.
          state_s      = RESP;
          resp_valid_s = 1'b1;
        end
      end
      DRAIN: begin
        state_s      = RESP;
        resp_valid_s = 1'b1;
      end
      RESP: begin
        if (resp_valid_r && fetch_resp_ready) begin
          state_s      = IDLE;
          idle_s       = 1'b1;
          resp_valid_s = 1'b0;
        end else begin
          resp_valid_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        idle_s  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      idle_r       <= 1'b0;
      pc_r         <= 64'd0;
      cnt_r        <= 4'd0;
      cap_idx_r    <= 4'd0;
      rd_pend_r    <= 1'b0;
      bytes_r      <= {BW{1'b0}};
      err_r        <= 1'b0;
      resp_valid_r <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= 8'h00;
      ld_error_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      idle_r       <= idle_s;
      pc_r         <= pc_s;
      cnt_r        <= cnt_s;
      cap_idx_r    <= cnt_r;
      rd_pend_r    <= mem_en_r & ~mem_we_r;
      bytes_r      <= bytes_s;
      err_r        <= err_s;
      resp_valid_r <= resp_valid_s;
      mem_en_r     <= mem_en_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      ld_error_r   <= ld_error_s;
    end
  end

  assign ld_ready         = idle_r;
  assign fetch_req_ready  = idle_r & ~ld_valid;
  assign fetch_resp_valid = resp_valid_r;
  assign fetch_bytes      = bytes_r;
  assign fetch_imem_error = err_r;
  assign ld_error         = ld_error_r;
  assign mem_en           = mem_en_r;
  assign mem_we           = mem_we_r;
  assign mem_addr         = mem_addr_r;
  assign mem_wdata        = mem_wdata_r;

endmodule
